// File: rtl/async_req_arbiter.sv
// ---------------------------------------------------------------------------
// async_req_arbiter
//
// Arbitrates N asynchronous request lines for one shared service resource.
// Each raw line passes through a two-flop synchronizer plus one history flop
// for rising-edge detection. Every detected edge latches a pending bit. A
// round-robin IDLE/GRANT state machine hands the resource to one requester
// at a time and holds the grant until the service unit pulses svc_done.
//
// Optional feature (compile-time macro TIMEOUT_EN):
//   defined   - an 8-bit cycle counter forces release of a grant that has
//               lasted TIMEOUT cycles without svc_done, pulsing timeout.
//   undefined - a grant waits indefinitely for svc_done; timeout tied 0.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  grant length in cycles before forced release (1..255)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   async_req  in   [N]   asynchronous request lines, rising edge = request
//   svc_done   in   1-cycle pulse from service unit: current job finished
//   grant_vld  out  grant active
//   grant_id   out  [IDW] granted requester (holds its value while idle)
//   pending    out  [N]   latched, not-yet-serviced requests
//   ovf        out  sticky: an edge arrived while its pending bit was set
//   timeout    out  1-cycle pulse on forced release
// ---------------------------------------------------------------------------
module async_req_arbiter #(
    parameter  int N       = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   async_req,
    input  logic           svc_done,
    output logic           grant_vld,
    output logic [IDW-1:0] grant_id,
    output logic [N-1:0]   pending,
    output logic           ovf,
    output logic           timeout
);

    if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("async_req_arbiter: N must be 2..8 and TIMEOUT 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_reg, state_next;

    logic [N-1:0]   ff1_reg, ff2_reg, ff3_reg;
    logic [N-1:0]   rise;
    logic [N-1:0]   clr;
    logic [N-1:0]   ovf_hit;
    logic [N-1:0]   pending_reg, pending_next;
    logic           ovf_reg;
    logic [IDW-1:0] grant_id_reg;
    logic [IDW-1:0] last_id_reg;
    logic [IDW-1:0] pick_id;
    logic           done_evt;
    logic           to_evt;
    logic           release_evt;
    logic           start_evt;

    // -----------------------------------------------------------------------
    // Synchronizer and edge history. Reset loads ones so that a line already
    // high when reset releases is not mistaken for a fresh request.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_reg <= '1;
            ff2_reg <= '1;
            ff3_reg <= '1;
        end else begin
            ff1_reg <= async_req;
            ff2_reg <= ff1_reg;
            ff3_reg <= ff2_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Per-line edge detect and pending update. A rise on the same cycle as
    // the clear of that bit wins, so the new request is never lost.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_line
            assign rise[gi]         = ff2_reg[gi] & ~ff3_reg[gi];
            assign clr[gi]          = release_evt && (grant_id_reg == IDW'(gi));
            assign ovf_hit[gi]      = rise[gi] & pending_reg[gi] & ~clr[gi];
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: search last_id+1, last_id+2, ... wrapping mod N.
    // The last candidate examined is last_id itself, so the requester served
    // most recently has the lowest priority.
    // -----------------------------------------------------------------------
    always_comb begin
        int  idx;
        logic found;
        pick_id = last_id_reg;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_id_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && pending_reg[idx]) begin
                pick_id = IDW'(idx);
                found   = 1'b1;
            end
        end
    end

    assign done_evt    = (state_reg == GRANT) && svc_done;
    assign release_evt = done_evt || to_evt;
    assign start_evt   = (state_reg == IDLE) && (pending_reg != '0);

`ifdef TIMEOUT_EN
    // Counter holds the number of GRANT cycles already completed, so the
    // terminal cycle is the one where it equals TIMEOUT-1; a grant therefore
    // lasts exactly TIMEOUT cycles. svc_done on that cycle wins.
    logic [7:0] cnt_reg;
    logic       timeout_reg;

    assign to_evt = (state_reg == GRANT) && !svc_done &&
                    (cnt_reg == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= to_evt;
            if (start_evt) begin
                cnt_reg <= '0;
            end else if (state_reg == GRANT) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign to_evt  = 1'b0;
    assign timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. Returning to IDLE on every release guarantees
    // at least one idle cycle between consecutive grants.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_evt)   state_next = GRANT;
            GRANT:   if (release_evt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        grant_vld = (state_reg == GRANT);
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg  <= '0;
            ovf_reg      <= 1'b0;
            grant_id_reg <= '0;
            last_id_reg  <= IDW'(N - 1);
        end else begin
            pending_reg <= pending_next;
            if (|ovf_hit) begin
                ovf_reg <= 1'b1;
            end
            if (start_evt) begin
                grant_id_reg <= pick_id;
            end
            if (release_evt) begin
                last_id_reg <= grant_id_reg;
            end
        end
    end

    assign grant_id = grant_id_reg;
    assign pending  = pending_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_async_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_async_req_arbiter
//
// Drives async_req_arbiter (N=4) with a short directed reset/edge sequence
// followed by randomized request toggling, svc_done pulses and occasional
// resets. A cycle-level reference model, written from the behavioural
// rules (input sample history, pending set, round-robin search), predicts
// every output; all outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_async_req_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef TIMEOUT_EN
    localparam int TO  = 8;
`else
    localparam int TO  = 255;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   async_req;
    logic           svc_done;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   pending;
    logic           ovf;
    logic           timeout;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    async_req_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .async_req (async_req),
        .svc_done  (svc_done),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .pending   (pending),
        .ovf       (ovf),
        .timeout   (timeout)
    );

    // ---------------- reference model state ----------------
    logic [N-1:0] hist [0:3];   // hist[j] = input sampled j edges ago
    logic [N-1:0] m_pend;
    logic         m_gv;
    int           m_gid;
    int           m_last;
    logic         m_ovf;
    logic         m_to;
    int           cyc = 0;
    int           g_start = 0;
    int           n_grants = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One posedge of the reference model, using the inputs that were stable
    // across that edge.
    task automatic model_edge();
        logic [N-1:0] rise_b;
        logic [N-1:0] clr_b;
        logic         to_n;
        cyc++;
        if (rst) begin
            for (int j = 0; j < 4; j++) hist[j] = '1;
            m_pend = '0;
            m_gv   = 1'b0;
            m_gid  = 0;
            m_last = N - 1;
            m_ovf  = 1'b0;
            m_to   = 1'b0;
            return;
        end
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = async_req;
        // input high two edges ago, low three edges ago => new request now
        rise_b = hist[2] & ~hist[3];
        clr_b  = '0;
        to_n   = 1'b0;
        if (m_gv) begin
            if (svc_done) begin
                clr_b[m_gid] = 1'b1;
                m_last       = m_gid;
                m_gv         = 1'b0;
            end
`ifdef TIMEOUT_EN
            else if (cyc - g_start == TO) begin
                clr_b[m_gid] = 1'b1;
                m_last       = m_gid;
                m_gv         = 1'b0;
                to_n         = 1'b1;
            end
`endif
        end else if (m_pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (!m_gv && m_pend[(m_last + k) % N]) begin
                    m_gid = (m_last + k) % N;
                    m_gv  = 1'b1;
                end
            end
            g_start = cyc;
            n_grants++;
            $display("grant cycle=%0d id=%0d pending=%b", cyc, m_gid, m_pend);
        end
        if ((rise_b & m_pend & ~clr_b) != '0) m_ovf = 1'b1;
        m_pend = (m_pend & ~clr_b) | rise_b;
        m_to   = to_n;
    endtask

    task automatic compare_all();
        check_eq("grant_vld", 32'(grant_vld), 32'(m_gv));
        check_eq("grant_id",  32'(grant_id),  32'(m_gid));
        check_eq("pending",   32'(pending),   32'(m_pend));
        check_eq("ovf",       32'(ovf),       32'(m_ovf));
        check_eq("timeout",   32'(timeout),   32'(m_to));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst       = 1'b1;
        async_req = 4'b0001;
        svc_done  = 1'b0;

        // Line already high through reset must not register a request.
        cycle();
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        check_eq("no_pend_after_rst", 32'(pending), 32'd0);

        // Drop and re-raise bit0: pending only on the third posedge.
        async_req = 4'b0000;
        repeat (3) cycle();
        async_req = 4'b0001;
        cycle();
        cycle();
        check_eq("pend0_2nd_edge", 32'(pending[0]), 32'd0);
        cycle();
        check_eq("pend0_3rd_edge", 32'(pending[0]), 32'd1);
        cycle();
        check_eq("grant_after_pend", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd0}));
        svc_done = 1'b1;
        cycle();
        svc_done = 1'b0;
        check_eq("release_vld", 32'(grant_vld), 32'd0);
        check_eq("release_pend", 32'(pending), 32'd0);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) async_req[b] = ~async_req[b];
            end
`ifdef TIMEOUT_EN
            svc_done = m_gv ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 9) == 0);
`else
            svc_done = m_gv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
`endif
            cycle();
        end

        check_eq("some_grants", 32'(n_grants > 50), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
